// File: rtl/stream_pkg.sv
// Shared types and helpers for the image streamer: state encoding, sample word, burst length.
package stream_pkg;

    localparam int unsigned DEF_NO_CH = 2;

    typedef logic [DEF_NO_CH-1:0] sample_t;

    typedef logic [1:0] streamer_state_t;
    localparam streamer_state_t IDLE   = 2'd0;
    localparam streamer_state_t STREAM = 2'd1;
    localparam streamer_state_t GAP    = 2'd2;

    function automatic int unsigned img_len_f(input int unsigned log2_img_size,
                                              input int unsigned ser_cyc);
        return 32'd1 << (log2_img_size + $clog2(ser_cyc));
    endfunction

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank sample buffer: one write port, one registered read port; bank select is the address MSB.
module pingpong_ram #(
    parameter int unsigned DW = 2,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW:0]   raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**(AW+1)];

    // Storage is never cleared; only the output register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/image_streamer.sv
// Ping-pong buffered feeder emitting each image as one contiguous burst of IMG_LEN beats.
// Optional STREAMER_GUARD_GAP_EN inserts GAP_CYC idle cycles after every image.
module image_streamer
    import stream_pkg::*;
#(
    parameter int unsigned NO_CH         = 2,
    parameter int unsigned LOG2_IMG_SIZE = 10,
`ifdef STREAMER_GUARD_GAP_EN
    parameter int unsigned GAP_CYC       = 2,
`endif
    parameter int unsigned SER_CYC       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [NO_CH-1:0] in_data,
    output logic             in_rdy,
    output logic             vld_out,
    output logic [NO_CH-1:0] data_out,
    output logic             img_first,
    output logic             img_last,
    output logic [15:0]      img_cnt
);

    localparam int unsigned AW      = LOG2_IMG_SIZE + $clog2(SER_CYC);
    localparam int unsigned IMG_LEN = img_len_f(LOG2_IMG_SIZE, SER_CYC);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_LEN - 1);

    logic            wr_bank_q;
    logic [AW-1:0]   wr_addr_q;
    logic [1:0]      full_q, full_d;
    logic            rd_bank_q;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    streamer_state_t state_q, state_d;
    logic            vld_q, first_q, last_q;
    logic [15:0]     img_cnt_q;
    logic            accept, wr_done, rd_issue, rd_done;

`ifdef STREAMER_GUARD_GAP_EN
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    logic [GW-1:0] gap_cnt_q;
`endif

    // Gated with rst so the source sees "not ready" for the whole reset window.
    assign in_rdy   = !rst && !full_q[wr_bank_q];
    assign accept   = in_vld && in_rdy;
    assign wr_done  = accept && (wr_addr_q == LAST_ADDR);
    assign rd_issue = (state_q == STREAM);
    assign rd_done  = rd_issue && (rd_addr_q == LAST_ADDR);

    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = STREAM;
                    rd_addr_d = '0;
                end
            end
            STREAM: begin
                rd_addr_d = rd_addr_q + AW'(1);
                if (rd_done) begin
`ifdef STREAMER_GUARD_GAP_EN
                    state_d = GAP;
`else
                    // Address wraps to 0, so a full partner bank streams on without a bubble.
                    if (!full_q[~rd_bank_q]) state_d = IDLE;
`endif
                end
            end
`ifdef STREAMER_GUARD_GAP_EN
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (full_q[rd_bank_q]) begin
                        state_d   = STREAM;
                        rd_addr_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            full_q    <= '0;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
            state_q   <= IDLE;
            vld_q     <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            img_cnt_q <= '0;
        end else begin
            if (accept) wr_addr_q <= wr_addr_q + AW'(1);
            if (wr_done) wr_bank_q <= ~wr_bank_q;
            if (rd_done) rd_bank_q <= ~rd_bank_q;
            full_q    <= full_d;
            rd_addr_q <= rd_addr_d;
            state_q   <= state_d;
            vld_q     <= rd_issue;
            first_q   <= rd_issue && (rd_addr_q == '0);
            last_q    <= rd_done;
            img_cnt_q <= img_cnt_q + 16'(rd_done);
        end
    end

`ifdef STREAMER_GUARD_GAP_EN
    always_ff @(posedge clk) begin
        if (rst || state_q != GAP) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
        end
    end
`endif

    pingpong_ram #(
        .DW(NO_CH),
        .AW(AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr ({wr_bank_q, wr_addr_q}),
        .wdata (in_data),
        .re    (rd_issue),
        .raddr ({rd_bank_q, rd_addr_q}),
        .rdata (data_out)
    );

    assign vld_out   = vld_q;
    assign img_first = first_q;
    assign img_last  = last_q;
    assign img_cnt   = img_cnt_q;

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer with IMG_LEN=4, NO_CH=2.
module tb_image_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [1:0]  in_data;
    logic        in_rdy;
    logic        vld_out;
    logic [1:0]  data_out;
    logic        img_first;
    logic        img_last;
    logic [15:0] img_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [1:0] beat_d [256];
    logic       beat_f [256];
    logic       beat_l [256];
    int         beat_c [256];
    int         nb = 0;

    logic [1:0] exp_bp [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0,
                                2'd1, 2'd3, 2'd0, 2'd2};
    logic [1:0] exp_bu [4]  = '{2'd2, 2'd0, 2'd3, 2'd1};
    logic [1:0] exp_rs [4]  = '{2'd3, 2'd1, 2'd2, 2'd0};

    image_streamer #(
        .NO_CH         (2),
        .LOG2_IMG_SIZE (2),
        .SER_CYC       (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .in_rdy    (in_rdy),
        .vld_out   (vld_out),
        .data_out  (data_out),
        .img_first (img_first),
        .img_last  (img_last),
        .img_cnt   (img_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vld_out === 1'b1 && nb < 256) begin
            beat_d[nb] <= data_out;
            beat_f[nb] <= img_first;
            beat_l[nb] <= img_last;
            beat_c[nb] <= cyc;
            nb         <= nb + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] d);
        int n = 0;
        bit done = 1'b0;
        in_vld  = 1'b1;
        in_data = d;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_rdy === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        in_vld = 1'b0;
        if (!done) chk("send_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_beats(input int target, input string name);
        int n = 0;
        while (nb < target && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 32'(nb >= target), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int last_wr;
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_data = '0;

        // Reset values
        idle(3);
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_vld_out", 32'(vld_out), 32'd0);
        chk("rst_first", 32'(img_first), 32'd0);
        chk("rst_last", 32'(img_last), 32'd0);
        chk("rst_img_cnt", 32'(img_cnt), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);
        idle(2);
        chk("empty_no_vld", 32'(nb), 32'd0);

        // Single image: first beat two edges after the last write edge
        base = nb;
        for (int i = 0; i < 4; i++) send(2'(i));
        last_wr = cyc;
        wait_beats(base + 4, "single_beats");
        for (int i = 0; i < 4; i++) begin
            chk("single_data", 32'(beat_d[base + i]), 32'(i));
            chk("single_first", 32'(beat_f[base + i]), 32'(i == 0));
            chk("single_last", 32'(beat_l[base + i]), 32'(i == 3));
        end
        chk("single_latency", 32'(beat_c[base]), 32'(last_wr + 2));
        chk("single_contig", 32'(beat_c[base + 3] - beat_c[base]), 32'd3);
        chk("single_img_cnt", 32'(img_cnt), 32'd1);
        idle(6);

        // Backpressure: twelve samples pushed with no drain delay
        base = nb;
        for (int i = 0; i < 8; i++) send(exp_bp[i]);
        chk("bp_rdy_low", 32'(in_rdy), 32'd0);
        for (int i = 8; i < 12; i++) send(exp_bp[i]);
        wait_beats(base + 12, "bp_beats");
        for (int i = 0; i < 12; i++) chk("bp_data", 32'(beat_d[base + i]), 32'(exp_bp[i]));
        for (int k = 0; k < 3; k++) begin
            chk("bp_first", 32'(beat_f[base + 4 * k]), 32'd1);
            chk("bp_last", 32'(beat_l[base + 4 * k + 3]), 32'd1);
            chk("bp_mid_first", 32'(beat_f[base + 4 * k + 1]), 32'd0);
            chk("bp_contig", 32'(beat_c[base + 4 * k + 3] - beat_c[base + 4 * k]), 32'd3);
        end
`ifdef STREAMER_GUARD_GAP_EN
        chk("gap_between_imgs", 32'(beat_c[base + 4] - beat_c[base + 3]), 32'd3);
`else
        chk("b2b_between_imgs", 32'(beat_c[base + 4] - beat_c[base + 3]), 32'd1);
`endif
        idle(8);
        chk("bp_no_extra", 32'(nb), 32'(base + 12));
        chk("bp_img_cnt", 32'(img_cnt), 32'd4);

        // Bursty source: valid every other cycle
        base = nb;
        for (int i = 0; i < 4; i++) begin
            send(exp_bu[i]);
            idle(1);
        end
        wait_beats(base + 4, "bursty_beats");
        for (int i = 0; i < 4; i++) chk("bursty_data", 32'(beat_d[base + i]), 32'(exp_bu[i]));
        chk("bursty_contig", 32'(beat_c[base + 3] - beat_c[base]), 32'd3);
        chk("bursty_first", 32'(beat_f[base]), 32'd1);
        chk("bursty_last", 32'(beat_l[base + 3]), 32'd1);
        chk("bursty_img_cnt", 32'(img_cnt), 32'd5);
        idle(6);

        // Reset on beat 1 with a second image half-written
        for (int i = 0; i < 4; i++) send(2'(3 - i));
        send(2'd2);
        send(2'd2);
        idle(1);
        chk("rs_beat1_vld", 32'(vld_out), 32'd1);
        chk("rs_beat1_data", 32'(data_out), 32'd2);
        rst = 1'b1;
        idle(1);
        chk("rs_vld_drop", 32'(vld_out), 32'd0);
        chk("rs_img_cnt", 32'(img_cnt), 32'd0);
        chk("rs_in_rdy", 32'(in_rdy), 32'd0);
        rst = 1'b0;
        #1;
        chk("rs_in_rdy_back", 32'(in_rdy), 32'd1);
        base = nb;
        for (int i = 0; i < 4; i++) send(exp_rs[i]);
        wait_beats(base + 4, "rs_beats");
        for (int i = 0; i < 4; i++) chk("rs_data", 32'(beat_d[base + i]), 32'(exp_rs[i]));
        chk("rs_first", 32'(beat_f[base]), 32'd1);
        chk("rs_last", 32'(beat_l[base + 3]), 32'd1);
        idle(12);
        chk("rs_no_stale", 32'(nb), 32'(base + 4));
        chk("rs_final_cnt", 32'(img_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/image_streamer.md
Name: image_streamer

Overview:
- Transmit-side feeder for `windower_serial`: it accepts samples from a bursty, backpressured source and buffers them in a two-bank ping-pong RAM.
- It emits each complete image as one uninterrupted burst of IMG_LEN valid beats, which meets the windower's contiguous-image contract.
- It sits between the ADC/sample-capture front end and the first windower of the conv pipeline.

Parameters:
- NO_CH, 2: bits per sample (channels).
- LOG2_IMG_SIZE, 10: log2 of image length in samples.
- SER_CYC, 1: serialisation factor, power of 2; the image burst length is IMG_LEN = 2^(LOG2_IMG_SIZE + log2(SER_CYC)).
- GAP_CYC, 2: idle cycles inserted between images when STREAMER_GUARD_GAP_EN is defined; must be >= 1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- in_vld, input, 1: source sample valid.
- in_data, input, NO_CH: source sample.
- in_rdy, output, 1: buffer can accept; a sample is accepted when in_vld & in_rdy.
- vld_out, output, 1: image beat valid; drives the windower vld_in.
- data_out, output, NO_CH: image beat; drives the windower data_in.
- img_first, output, 1: qualifies the first beat of an image (with vld_out).
- img_last, output, 1: qualifies the last beat of an image (with vld_out).
- img_cnt, output, 16: images fully emitted, wraps modulo 2^16.

Behaviour:
- Reset values: in_rdy=0 during reset, then 1 from the first cycle after rst deasserts. vld_out=0, img_first=0, img_last=0, img_cnt=0, data_out=0.
- Reset state: both bank-full flags cleared, write pointer at bank 0 address 0, read FSM in IDLE.
- Reset mid-operation: partially written or partially streamed images are discarded; vld_out drops the cycle after the rst edge. RAM contents are not cleared.
- Write side:
  - in_rdy = !full[wr_bank].
  - On an accepted sample, write mem[wr_bank][wr_addr] and increment wr_addr (width log2(IMG_LEN), wraps to 0).
  - When the accepted sample has wr_addr == IMG_LEN-1: set full[wr_bank] and toggle wr_bank.
- Read FSM states: IDLE, STREAM, GAP (GAP exists only with the macro).
- IDLE:
  - If full[rd_bank], go to STREAM and issue rd_addr=0.
  - Latency: last sample accepted at edge E → full flag visible after E → edge E+1 enters STREAM → edge E+2 registers data_out=mem[0], vld_out=1, img_first=1.
- STREAM:
  - Issue one read per cycle with rd_addr incrementing; the registered RAM output gives a fixed 1-cycle read latency.
  - vld_out is high for exactly IMG_LEN consecutive cycles. img_last coincides with beat IMG_LEN-1.
  - When the read of IMG_LEN-1 is issued: clear full[rd_bank], toggle rd_bank, and increment img_cnt on that same edge.
  - If the other bank is already full at that point (macro off), continue straight to rd_addr=0 of the new bank. The next image's first beat then directly follows the previous last beat (zero gap). Otherwise go to IDLE.
- Simultaneous events:
  - Clearing full[b] on the read side and a write to bank b on the same edge is legal; the write targets the freed bank only from the next cycle, because in_rdy is evaluated on the registered flag.
  - Setting and clearing different banks' flags in the same cycle are independent.
- Both banks full: in_rdy=0; the source stalls and no data is dropped.
- Empty: vld_out stays 0 and no partial image is ever emitted.
- Ordering: images are emitted in arrival order and samples within an image are emitted in arrival order.

Optional Feature:
- Macro: STREAMER_GUARD_GAP_EN.
- Defined: after each img_last beat the FSM enters GAP and holds vld_out=0 for exactly GAP_CYC cycles, then goes to IDLE. This guarantees the windower its !vld_in flush cycles between images.
- Undefined: the GAP state and GAP_CYC logic are absent, and back-to-back images have zero gap.

Decomposition:
- Shared package `stream_pkg`:
  - localparam helper for IMG_LEN.
  - typedef enum {IDLE, STREAM, GAP} streamer_state_t.
  - typedef for the sample word, logic [NO_CH-1:0].
- One natural sub-module, `pingpong_ram`: dual bank, one write port and one registered read port, with bank select folded into the MSB of the address.

Test Plan (LOG2_IMG_SIZE=2, SER_CYC=1, IMG_LEN=4, NO_CH=2 unless noted):
- Single image:
  - Stimulus: write 0,1,2,3 on consecutive cycles.
  - Response: vld_out high for 4 cycles, starting 2 edges after the last write edge. data_out = 0,1,2,3; img_first on beat 0; img_last on beat 3; img_cnt=1.
- Backpressure:
  - Stimulus: write 12 samples continuously with no drain delay.
  - Response: in_rdy low after sample 8 until bank 0 frees. All 12 samples emitted in order as 3 images; none dropped; img_cnt=3.
- Bursty source:
  - Stimulus: in_vld toggles every cycle.
  - Response: output still contiguous 4-beat bursts; vld_out never deasserts inside an image.
- Back-to-back images (macro off):
  - Stimulus: two images fully buffered.
  - Response: 8 consecutive vld_out cycles; img_last on beat 3 immediately followed by img_first on beat 4.
- Guard gap:
  - Stimulus: same as the back-to-back case, with STREAMER_GUARD_GAP_EN and GAP_CYC=2.
  - Response: exactly 2 cycles of vld_out=0 between beat 3 and beat 4.
- Reset mid-stream:
  - Stimulus: assert rst on beat 1 of an image with a second image half-written.
  - Response: vld_out=0 the next cycle, img_cnt=0. A fresh image written afterwards is emitted correctly with no stale samples.
